// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low segment patterns,
// digit-slot indices and the all-off anode value.
package stopwatch_pkg;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [1:0] DIG_TEN = 2'd0;
    localparam logic [1:0] DIG_SEC = 2'd1;
    localparam logic [1:0] DIG_MIN = 2'd2;

    localparam logic [2:0] AN_OFF = 3'b111;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 render as a dash
// so a corrupted time bus is visible rather than silently wrong.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// Three-digit multiplexed common-anode display driver with lap-freeze shadow,
// blink and blanking. Define STOPWATCH_DISP_LZB_EN to blank a leading zero minute.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] minutes_bcd,
    input  logic [3:0] seconds_bcd,
    input  logic [3:0] tenths_bcd,
    input  logic       load,
    input  logic       flash_req,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [3:0]    sh_min, sh_sec, sh_ten;
    logic [1:0]    idx;
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    phase_t        phase, phase_nxt;
    logic          flash_q;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic          lzb_dark;
    logic [2:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // The output stage looks at the phase being written this edge, so the
    // first dark cycle coincides with the flash_req rising edge.
    always_comb begin
        blink_cnt_nxt = blink_cnt + 1'b1;
        phase_nxt     = phase;
        if (flash_req && !flash_q) begin
            blink_cnt_nxt = '0;
            phase_nxt     = PH_OFF;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            phase_nxt     = (phase == PH_OFF) ? PH_ON : PH_OFF;
        end
    end

    always_comb begin
        case (idx)
            DIG_SEC: digit = sh_sec;
            DIG_MIN: digit = sh_min;
            default: digit = sh_ten;
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

`ifdef STOPWATCH_DISP_LZB_EN
    assign lzb_dark = (idx == DIG_MIN) && (sh_min == 4'd0);
`else
    assign lzb_dark = 1'b0;
`endif

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (!blank && !(flash_req && phase_nxt == PH_OFF) && !lzb_dark) begin
            an_nxt  = ~(3'b001 << idx);
            seg_nxt = seg_dec;
            dp_nxt  = (idx != DIG_SEC);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_min    <= '0;
            sh_sec    <= '0;
            sh_ten    <= '0;
            idx       <= DIG_TEN;
            scan_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= PH_OFF;
            flash_q   <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            if (load) begin
                sh_min <= minutes_bcd;
                sh_sec <= seconds_bcd;
                sh_ten <= tenths_bcd;
            end
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == DIG_MIN) ? DIG_TEN : idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            flash_q   <= flash_req;
            an        <= an_nxt;
            seg       <= seg_nxt;
            dp        <= dp_nxt;
        end
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Consumer side of the stopwatch time bus: captures the stopwatch's `minutes_bcd` / `seconds_bcd` / `tenths_bcd` digits and drives a 3-digit, time-multiplexed, common-anode seven-segment display. Provides a decimal point after seconds, a whole-display blink on request, forced blanking, and a lap-freeze shadow register. It sits between the stopwatch core and the board display pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is lit. Must be ≥ 2.
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period. Must be ≥ 2.
- `clk` in 1: the single system clock.
- `reset` in 1: synchronous, active-low; reset takes effect when `reset == 0` at a `clk` edge.
- `minutes_bcd` in 4: minutes digit, BCD.
- `seconds_bcd` in 4: seconds digit, BCD.
- `tenths_bcd` in 4: tenths digit, BCD.
- `load` in 1: a 1 at a clock edge captures the three digits into the shadow register. Hold it at 1 for continuous tracking; drop it to 0 to freeze the display (lap).
- `flash_req` in 1: blink the whole display while high.
- `blank` in 1: force the display dark. Highest priority.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 3: digit enables, active-low. Bit 0 is tenths, bit 1 is seconds, bit 2 is minutes.

## Operation
- **Shadow register:** `sh_min`, `sh_sec`, `sh_ten`. Loaded at every edge where `load=1`; otherwise holds.
- **Scan counter:** counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→0. Index value 3 is never reached.
- **Decode:** 0–9 use the standard patterns (0 = 7'b1000000, 8 = 7'b0000000). Codes 10–15 show a dash (7'b0111111).
- **Decimal point:** `dp=0` only while index = 1 (seconds). Otherwise `dp=1`.
- **Blink:**
  - A blink counter counts 0..BLINK_DIV-1. `phase` toggles at each terminal count.
  - On the rising edge of `flash_req` (registered edge detect), the counter clears and `phase` is set to OFF.
  - While `flash_req=1` and `phase=OFF`: `an=3'b111`.
  - While `flash_req=0`: `phase` is ignored.
- **Priority, per cycle:**
  1. `blank=1` gives `an=3'b111`, `seg=7'h7F`, `dp=1`.
  2. Otherwise the blink-off phase gives the same all-dark outputs.
  3. Otherwise `an` is one-hot-low at the current index, and `seg`/`dp` come from that index's shadow digit.
- **Registered outputs:** `an`, `seg` and `dp` are all registered, so there are no combinational paths from inputs to pins.
- **Reset:** all of the following are cleared.
  - Shadow digits = 0, index = 0, scan counter = 0, blink counter = 0, `phase` = OFF, edge-detect register = 0.
  - `an=3'b111`, `seg=7'h7F`, `dp=1`.

## Timing
- **Load latency:** `load` sampled at edge N updates the shadow at N. A lit digit shows the new value from edge N+1.
- **Index dwell:** index changes at the edge where the scan counter wraps. `an` and `seg` follow one edge later, and always change together (no ghosting cycle with a mismatched pair).
- **Full refresh:** 3·SCAN_DIV cycles.
- **`blank` / `flash_req` response:** asserting or deasserting either affects the outputs at the next edge.
- **`flash_req` held high:** the display is dark for BLINK_DIV cycles, lit for BLINK_DIV cycles, and repeats.
- **Reset mid-scan:** the first lit output after reset release is index 0 (tenths), one edge after release. The scan counter restarts from 0.
- **Simultaneous `load` and `blank`:** the shadow still loads. Only the outputs are dark.

## Configuration
- `STOPWATCH_DISP_LZB_EN`
  - Defined: leading-zero blanking. When `sh_min == 0`, the minutes digit stays dark during its slot (`an[2]=1`). The scan timing is unchanged.
  - Undefined: minutes zero displays as "0".

## Structure
- **Package `stopwatch_pkg`:**
  - Segment constants: `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`.
  - Digit-index localparams: `DIG_TEN=0`, `DIG_SEC=1`, `DIG_MIN=2`.
  - `AN_OFF = 3'b111`.
- **Sub-module `seg7_decode`:** combinational, 4-bit BCD to 7-bit active-low. Instantiated once, fed by the index mux.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=8.
- **Reset:** hold `reset=0` for 3 cycles with inputs 3/4/5 → `an=111`, `seg=7F`, `dp=1`. After release with `load=1`: `an=110` with `seg=SEG_5` (tenths) one edge later; after 4 cycles `an=101`, `seg=SEG_4`, `dp=0`; then `an=011`, `seg=SEG_3`.
- **Lap freeze:** track 1/2/3 with `load=1`, drop `load` to 0, change the inputs to 9/9/9 → display stays 1/2/3 until `load=1`. Then 9s appear on the next lit slot.
- **Invalid BCD:** `tenths_bcd=4'hC` → tenths slot shows `seg=7'b0111111`.
- **Blink:** raise `flash_req` → dark for 8 cycles, scanning for 8 cycles, repeating. Drop `flash_req` mid-dark → lit at the next edge.
- **Blank priority:** `blank=1` during a blink-lit phase with `load=1` → outputs all dark, shadow still updates (verified after `blank=0`).
- **Macro:** with `STOPWATCH_DISP_LZB_EN` defined and minutes=0 → `an[2]` never goes low. Undefined → minutes slot shows `SEG_0`.
